fp_norm_shift: RTL and testbench

FP_NORM_SHIFT -- requirements
Module: fp_norm_shift

---
 rtl/fp_norm_shift.sv | 226 ++++++++++++++++++++++
 tb/tb_fp_norm_shift.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_norm_shift.sv
// -----------------------------------------------------------------------------
// fp_norm_shift
//
// Two-stage floating-point normalisation shifter. An unnormalised mantissa,
// its exponent and a precomputed leading-zero count come in. The mantissa
// leaves shifted left so that its leading one sits at the MSB, and the
// exponent is reduced by the same amount. The exponent never goes below
// zero. When the exponent runs out before the leading one reaches the MSB,
// the result is flagged as denormal and its exponent is forced to 0. An
// all-zero input mantissa produces an exact-zero result.
//
//   S1 : register the input beat, the clamped shift amount and the clamp flag
//   S2 : register the shifted mantissa, the adjusted exponent and the flags
//
// Ports
//   Clk_CI       in   clock, rising edge
//   Rst_RBI      in   asynchronous active-low reset
//   Valid_SI     in   input beat valid
//   Ready_SO     out  input beat is accepted when Valid_SI & Ready_SO
//   Mant_DI      in   unnormalised mantissa            [C_WIDTH]
//   Exp_DI       in   unsigned biased exponent         [C_EXP_WIDTH]
//   LeadZero_DI  in   leading-zero count of Mant_DI    [C_LEADONE_WIDTH]
//   NoOne_SI     in   Mant_DI is all zero
//   Valid_SO     out  output beat valid
//   Ready_SI     in   downstream accepts when Valid_SO & Ready_SI
//   Mant_DO      out  normalised mantissa              [C_WIDTH]
//   Exp_DO       out  adjusted exponent                [C_EXP_WIDTH]
//   Denorm_SO    out  exponent exhausted, result is denormal
//   Zero_SO      out  result is exact zero
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. A producer holds valid and its data steady until that edge.
// Ready may depend on the consumer's ready within the same cycle, but it
// never depends on valid. While Valid_SO is high and Ready_SI is low, every
// output holds stable.
// -----------------------------------------------------------------------------
module fp_norm_shift #(
    parameter int C_WIDTH         = 51,
    parameter int C_LEADONE_WIDTH = 6,
    parameter int C_EXP_WIDTH     = 11
) (
    input  logic                       Clk_CI,
    input  logic                       Rst_RBI,

    input  logic                       Valid_SI,
    output logic                       Ready_SO,
    input  logic [C_WIDTH-1:0]         Mant_DI,
    input  logic [C_EXP_WIDTH-1:0]     Exp_DI,
    input  logic [C_LEADONE_WIDTH-1:0] LeadZero_DI,
    input  logic                       NoOne_SI,

    output logic                       Valid_SO,
    input  logic                       Ready_SI,
    output logic [C_WIDTH-1:0]         Mant_DO,
    output logic [C_EXP_WIDTH-1:0]     Exp_DO,
    output logic                       Denorm_SO,
    output logic                       Zero_SO
);

    // Common width for comparing the leading-zero count against the exponent
    // and against the largest useful shift, C_WIDTH-1. Because
    // 2^C_LEADONE_WIDTH >= C_WIDTH, C_WIDTH-1 always fits in the count width.
    localparam int CMP_W = (C_LEADONE_WIDTH > C_EXP_WIDTH) ? C_LEADONE_WIDTH
                                                           : C_EXP_WIDTH;

    // ------------------------------------------------------------------
    // Stage registers
    // ------------------------------------------------------------------
    logic                       s1_valid;
    logic [C_WIDTH-1:0]         s1_mant;
    logic [C_EXP_WIDTH-1:0]     s1_exp;
    logic                       s1_noone;
    logic [C_LEADONE_WIDTH-1:0] s1_shamt;
    logic                       s1_clamp;

    logic                       s2_valid;

    // ------------------------------------------------------------------
    // Flow control
    // ------------------------------------------------------------------
    logic s2_free;   // S2 can take a new beat on this edge
    logic s1_free;   // S1 can take a new beat on this edge
    logic s1_load;   // input beat is transferred into S1
    logic s2_load;   // S1 beat is transferred into S2

    // S2 frees up when it is empty or when its beat leaves downstream.
    // S1 frees up when it is empty or when its beat moves into S2. With both
    // stages full and Ready_SI high, all stages advance together. That gives
    // one beat per cycle without bubbles.
    assign s2_free  = ~s2_valid | Ready_SI;
    assign s1_free  = ~s1_valid | s2_free;
    assign Ready_SO = s1_free;
    assign s1_load  = Valid_SI & s1_free;
    assign s2_load  = s1_valid & s2_free;
    assign Valid_SO = s2_valid;

    // ------------------------------------------------------------------
    // S1 combinational: shift amount and clamp detection
    // ------------------------------------------------------------------
    logic [CMP_W-1:0]           lz_ext;
    logic [CMP_W-1:0]           exp_ext;
    logic [CMP_W-1:0]           shift_limit;
    logic [CMP_W-1:0]           lz_eff;
    logic [CMP_W-1:0]           shamt_full;
    logic [C_LEADONE_WIDTH-1:0] shamt_d;
    logic                       clamp_d;

    assign lz_ext      = CMP_W'(LeadZero_DI);
    assign exp_ext     = CMP_W'(Exp_DI);
    assign shift_limit = CMP_W'(C_WIDTH - 1);

    always_comb begin
        lz_eff     = lz_ext;
        shamt_full = '0;
        // A count of C_WIDTH or more can only come from a zero mantissa.
        // When NoOne_SI is low, such a count is treated as the largest
        // shift that still keeps a bit.
        if (lz_ext > shift_limit) begin
            lz_eff = shift_limit;
        end
        // The shift cannot exceed the exponent. Otherwise the exponent
        // would wrap below zero.
        if (lz_eff < exp_ext) begin
            shamt_full = lz_eff;
        end else begin
            shamt_full = exp_ext;
        end
    end

    // shamt_full <= C_WIDTH-1, so it fits the count width without loss.
    assign shamt_d = C_LEADONE_WIDTH'(shamt_full);
    assign clamp_d = lz_ext > exp_ext;

    // ------------------------------------------------------------------
    // S2 combinational: shift, exponent adjust, flags
    // ------------------------------------------------------------------
    logic [C_WIDTH-1:0]     mant_shifted;
    logic [C_EXP_WIDTH-1:0] exp_adjusted;
    logic [C_WIDTH-1:0]     mant_d;
    logic [C_EXP_WIDTH-1:0] exp_d;
    logic                   denorm_d;
    logic                   zero_d;

    assign mant_shifted = s1_mant << s1_shamt;
    // s1_shamt <= s1_exp, so the subtraction never underflows. The cast
    // only drops leading zeros when the count is wider than the exponent.
    assign exp_adjusted = s1_exp - C_EXP_WIDTH'(s1_shamt);

    always_comb begin
        mant_d   = mant_shifted;
        exp_d    = exp_adjusted;
        denorm_d = 1'b0;
        zero_d   = 1'b0;
        if (s1_noone) begin
            // Exact zero overrides everything that came with the beat.
            mant_d = '0;
            exp_d  = '0;
            zero_d = 1'b1;
        end else if (s1_clamp) begin
            // The exponent ran out before the leading one reached the MSB.
            // When the exponent is larger than the maximum shift, the
            // difference is not zero, so the exponent is forced to 0 here.
            exp_d    = '0;
            denorm_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Valid bits
    // ------------------------------------------------------------------
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (s1_load) begin
                s1_valid <= 1'b1;
            end else if (s2_load) begin
                s1_valid <= 1'b0;
            end

            if (s2_load) begin
                s2_valid <= 1'b1;
            end else if (Ready_SI) begin
                s2_valid <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // S1 data
    // ------------------------------------------------------------------
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            s1_mant  <= '0;
            s1_exp   <= '0;
            s1_noone <= 1'b0;
            s1_shamt <= '0;
            s1_clamp <= 1'b0;
        end else if (s1_load) begin
            s1_mant  <= Mant_DI;
            s1_exp   <= Exp_DI;
            s1_noone <= NoOne_SI;
            s1_shamt <= shamt_d;
            s1_clamp <= clamp_d;
        end
    end

    // ------------------------------------------------------------------
    // S2 data, which drives the outputs directly
    // ------------------------------------------------------------------
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            Mant_DO   <= '0;
            Exp_DO    <= '0;
            Denorm_SO <= 1'b0;
            Zero_SO   <= 1'b0;
        end else if (s2_load) begin
            Mant_DO   <= mant_d;
            Exp_DO    <= exp_d;
            Denorm_SO <= denorm_d;
            Zero_SO   <= zero_d;
        end
    end

endmodule

// File: tb/tb_fp_norm_shift.sv
// -----------------------------------------------------------------------------
// tb_fp_norm_shift
//
// Directed bench for fp_norm_shift with C_WIDTH=8, C_LEADONE_WIDTH=4 and
// C_EXP_WIDTH=5. Inputs are driven on the falling edge. Outputs are sampled
// 1 ns later, well away from the rising edge. Expected beats are packed as
// {zero, denorm, exp[4:0], mant[7:0]} and queued in exp_q.
// -----------------------------------------------------------------------------
module tb_fp_norm_shift;

    localparam int W  = 8;
    localparam int LW = 4;
    localparam int EW = 5;
    localparam int PW = 2 + EW + W;

    // ---------------- clock / reset ----------------
    logic          clk;
    logic          rst_n;
    logic          valid_si;
    logic          ready_so;
    logic [W-1:0]  mant_di;
    logic [EW-1:0] exp_di;
    logic [LW-1:0] lz_di;
    logic          noone_si;
    logic          valid_so;
    logic          ready_si;
    logic [W-1:0]  mant_do;
    logic [EW-1:0] exp_do;
    logic          denorm_so;
    logic          zero_so;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    fp_norm_shift #(
        .C_WIDTH         (W),
        .C_LEADONE_WIDTH (LW),
        .C_EXP_WIDTH     (EW)
    ) dut (
        .Clk_CI      (clk),
        .Rst_RBI     (rst_n),
        .Valid_SI    (valid_si),
        .Ready_SO    (ready_so),
        .Mant_DI     (mant_di),
        .Exp_DI      (exp_di),
        .LeadZero_DI (lz_di),
        .NoOne_SI    (noone_si),
        .Valid_SO    (valid_so),
        .Ready_SI    (ready_si),
        .Mant_DO     (mant_do),
        .Exp_DO      (exp_do),
        .Denorm_SO   (denorm_so),
        .Zero_SO     (zero_so)
    );

    // ---------------- scoreboard state ----------------
    logic [PW-1:0] exp_q[$];
    int checks     = 0;
    int failures   = 0;
    int cyc        = 0;
    int emit_cnt   = 0;
    int first_emit = -1;
    int last_emit  = -1;

    function automatic logic [PW-1:0] pk(input logic z, input logic d,
                                         input logic [EW-1:0] e,
                                         input logic [W-1:0] m);
        return {z, d, e, m};
    endfunction

    // Reference: shift one bit at a time, by min(LZ, Exp). An LZ of W or
    // more counts as W-1.
    function automatic logic [PW-1:0] model(input logic [W-1:0] m,
                                            input logic [EW-1:0] e,
                                            input logic [LW-1:0] lz,
                                            input logic no);
        int         sh;
        int         eo;
        logic [W-1:0] mm;
        logic       den;
        if (no) return pk(1'b1, 1'b0, '0, '0);
        sh = (int'(lz) >= W) ? W - 1 : int'(lz);
        if (int'(e) < sh) sh = int'(e);
        mm = m;
        for (int i = 0; i < sh; i++) mm = {mm[W-2:0], 1'b0};
        den = int'(lz) > int'(e);
        eo  = den ? 0 : int'(e) - sh;
        return pk(1'b0, den, EW'(eo), mm);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // ---------------- driver: one cycle ----------------
    // Drives the inputs on the falling edge, then checks the output beat
    // against the head of exp_q. The head is popped only when the beat is
    // taken. During stalls the head is compared again on every cycle, so
    // the outputs must stay unchanged.
    task automatic cycle(input logic v, input logic [W-1:0] m,
                         input logic [EW-1:0] e, input logic [LW-1:0] lz,
                         input logic no, input logic rdy, output logic acc);
        logic [PW-1:0] tmp;
        @(negedge clk);
        valid_si = v;
        mant_di  = m;
        exp_di   = e;
        lz_di    = lz;
        noone_si = no;
        ready_si = rdy;
        #1;
        acc = v & ready_so;
        if (valid_so) begin
            if (exp_q.size() == 0) begin
                chk("spurious_valid", 32'(valid_so), 32'd0);
            end else begin
                chk("beat", 32'({zero_so, denorm_so, exp_do, mant_do}),
                    32'(exp_q[0]));
                if (rdy) begin
                    tmp = exp_q.pop_front();
                    if (emit_cnt == 0) first_emit = cyc;
                    last_emit = cyc;
                    emit_cnt++;
                end
            end
        end
        cyc++;
    endtask

    task automatic idle();
        logic acc;
        cycle(1'b0, '0, '0, '0, 1'b0, 1'b1, acc);
    endtask

    // Sends one beat with a hand-computed result and checks the 2-cycle
    // latency.
    task automatic directed(input string tag, input logic [W-1:0] m,
                            input logic [EW-1:0] e, input logic [LW-1:0] lz,
                            input logic no, input logic [PW-1:0] expv);
        logic acc;
        cycle(1'b1, m, e, lz, no, 1'b1, acc);
        chk({tag, "_ready"}, 32'(ready_so), 32'd1);
        if (acc) exp_q.push_back(expv);
        idle();
        chk({tag, "_lat1"}, 32'(valid_so), 32'd0);
        idle();
        chk({tag, "_emitted"}, 32'(exp_q.size()), 32'd0);
    endtask

    // Waits a bounded number of cycles for exp_q to drain.
    task automatic drain(input string tag);
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) idle();
        chk({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic          acc;
        logic [W-1:0]  m;
        logic [EW-1:0] e;
        logic [LW-1:0] lz;
        logic          no;
        int            sent;
        logic [W-1:0]  bp_m[4];
        logic [EW-1:0] bp_e[4];
        logic [LW-1:0] bp_lz[4];

        rst_n = 1'b0;
        valid_si = 1'b0; mant_di = '0; exp_di = '0; lz_di = '0;
        noone_si = 1'b0; ready_si = 1'b1;
        #2;
        chk("reset_valid", 32'(valid_so), 32'd0);
        chk("reset_outs", 32'({zero_so, denorm_so, exp_do, mant_do}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset_ready", 32'(ready_so), 32'd1);

        // Directed single beats with hand-computed results
        directed("normal",   8'h14, 5'd10, 4'd3,  1'b0, pk(0, 0, 5'd7,  8'hA0));
        directed("clamp",    8'h03, 5'd2,  4'd6,  1'b0, pk(0, 1, 5'd0,  8'h0C));
        directed("zero",     8'h00, 5'd17, 4'd8,  1'b1, pk(1, 0, 5'd0,  8'h00));
        directed("lz_big",   8'h01, 5'd20, 4'd12, 1'b0, pk(0, 0, 5'd13, 8'h80));
        directed("exp_zero", 8'h01, 5'd0,  4'd7,  1'b0, pk(0, 1, 5'd0,  8'h01));
        directed("lz_eq_e",  8'h10, 5'd3,  4'd3,  1'b0, pk(0, 0, 5'd0,  8'h80));

        // Backpressure: Ready_SI low from cycle 2 through cycle 5
        bp_m  = '{8'h14, 8'h03, 8'h81, 8'h05};
        bp_e  = '{5'd10, 5'd2,  5'd4,  5'd9};
        bp_lz = '{4'd3,  4'd6,  4'd0,  4'd5};
        sent = 0;
        emit_cnt = 0;
        for (int c = 0; c < 30 && (sent < 4 || exp_q.size() > 0); c++) begin
            if (sent < 4) begin
                cycle(1'b1, bp_m[sent], bp_e[sent], bp_lz[sent], 1'b0,
                      !(c >= 2 && c <= 5), acc);
                if (acc) begin
                    exp_q.push_back(model(bp_m[sent], bp_e[sent], bp_lz[sent], 1'b0));
                    sent++;
                end
            end else begin
                idle();
            end
            if (c >= 2 && c <= 5) chk("bp_ready_low", 32'(ready_so), 32'd0);
        end
        chk("bp_emitted", 32'(emit_cnt), 32'd4);
        drain("bp");

        // Full rate: 16 back-to-back random beats
        sent = 0;
        emit_cnt = 0;
        for (int c = 0; c < 40 && (sent < 16 || exp_q.size() > 0); c++) begin
            if (sent < 16) begin
                m  = W'($urandom_range(0, 255));
                e  = EW'($urandom_range(0, 31));
                lz = LW'($urandom_range(0, 7));
                no = (m == '0);
                cycle(1'b1, m, e, lz, no, 1'b1, acc);
                if (acc) begin
                    exp_q.push_back(model(m, e, lz, no));
                    sent++;
                end
            end else begin
                idle();
            end
        end
        chk("fr_accepts", 32'(sent), 32'd16);
        chk("fr_emitted", 32'(emit_cnt), 32'd16);
        chk("fr_span", 32'(last_emit - first_emit), 32'd15);
        drain("fr");

        // Reset with 2 beats in flight
        cycle(1'b1, 8'h14, 5'd10, 4'd3, 1'b0, 1'b1, acc);
        if (acc) exp_q.push_back(pk(0, 0, 5'd7, 8'hA0));
        cycle(1'b1, 8'h03, 5'd2, 4'd6, 1'b0, 1'b1, acc);
        if (acc) exp_q.push_back(pk(0, 1, 5'd0, 8'h0C));
        @(negedge clk);
        valid_si = 1'b0;
        #1;
        chk("rst_pre_valid", 32'(valid_so), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_valid_low", 32'(valid_so), 32'd0);
        chk("rst_outs_zero", 32'({zero_so, denorm_so, exp_do, mant_do}), 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_ready", 32'(ready_so), 32'd1);
        idle();
        idle();
        idle();
        directed("post_rst", 8'h30, 5'd5, 4'd2, 1'b0, pk(0, 0, 5'd3, 8'hC0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
